// File: rtl/bitonic_pkg.sv
// Shared types and elaboration helpers for the iterative bitonic sorter.
package bitonic_pkg;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  function automatic int log2i(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Compare-and-swap substages needed for a full bitonic sort of depth keys.
  function automatic int nsub(input int depth);
    return log2i(depth) * (log2i(depth) + 1) / 2;
  endfunction

endpackage

// File: rtl/bitonic_cas_stage.sv
// One bitonic compare-and-swap substage (p,q) across the whole key bank; purely combinational.
module bitonic_cas_stage
  import bitonic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int PW    = $clog2(log2i(DEPTH) + 1)
) (
  input  logic [WIDTH-1:0] i_bank [0:DEPTH-1],
  input  logic [PW-1:0]    i_p,
  input  logic [PW-1:0]    i_q,
  output logic [WIDTH-1:0] o_bank [0:DEPTH-1]
);

  localparam int LOG2D = log2i(DEPTH);
  localparam int LW    = (LOG2D < 1) ? 1 : LOG2D;

  // Each lane computes its own result; the pair's lower index keeps the min when
  // ascending, so both lanes of a pair agree without sharing a swap flag.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
    logic [LW-1:0]    w_pidx;
    logic [WIDTH-1:0] w_self, w_peer, w_min, w_max;
    logic             w_asc, w_low;

    assign w_pidx = LW'(gi) ^ (LW'(1) << i_q);
    assign w_self = i_bank[gi];
    assign w_peer = i_bank[w_pidx];
    assign w_asc  = ((32'(gi) >> i_p) & 32'd1) == 32'd0;
    assign w_low  = w_pidx > LW'(gi);
    assign w_min  = (w_peer < w_self) ? w_peer : w_self;
    assign w_max  = (w_peer > w_self) ? w_peer : w_self;
    assign o_bank[gi] = (w_low == w_asc) ? w_min : w_max;
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Iterative bitonic sorter: one key bank, one shared CAS substage per cycle, FSM-sequenced.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] seq_in [0:DEPTH-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] seq_out [0:DEPTH-1],
  output logic             busy
);

  localparam int LOG2D = log2i(DEPTH);
  localparam int PW    = $clog2(LOG2D + 1);

  typedef logic [WIDTH-1:0] bank_t [0:DEPTH-1];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bitonic_sort_ctrl: DEPTH must be a power of 2 and >= 2");
  end

  state_t        r_state, w_state_nxt;
  bank_t         r_bank, w_bank_cas;
  logic [PW-1:0] r_p, r_q;
  logic          w_last, w_load;

  bitonic_cas_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW)) u_cas (
    .i_bank (r_bank),
    .i_p    (r_p),
    .i_q    (r_q),
    .o_bank (w_bank_cas)
  );

  assign w_last = (r_p == PW'(LOG2D)) && (r_q == '0);
  assign busy   = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !abort;
        if (in_valid && !abort) begin
          w_load      = 1'b1;
          w_state_nxt = SORT;
        end
      end
      SORT: if (w_last) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Counters are parked at zero after the last substage so p never exceeds LOG2D.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank <= '{default: '0};
      r_p    <= '0;
      r_q    <= '0;
    end else if (abort) begin
      r_p <= '0;
      r_q <= '0;
    end else if (w_load) begin
      r_bank <= seq_in;
      r_p    <= PW'(1);
      r_q    <= '0;
    end else if (r_state == SORT) begin
      r_bank <= w_bank_cas;
      if (w_last) begin
        r_p <= '0;
        r_q <= '0;
      end else if (r_q == '0) begin
        r_p <= r_p + PW'(1);
        r_q <= r_p;
      end else begin
        r_q <= r_q - PW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      seq_out[i] = out_valid ? r_bank[i] : '0;
  end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Bench for bitonic_sort_ctrl: D=8 and D=2 instances against a queue-and-countdown reference model.
module tb_bitonic_sort_ctrl;
  import bitonic_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ab [2], iv [2], ordy [2], ir [2], ov [2], bz [2];
  logic [31:0] s8 [0:7], o8 [0:7], s2 [0:1], o2 [0:1];
  logic [31:0] vin [0:7], vexp [0:7];
  logic [31:0] m_res [2][0:7];
  int          m_st [2], m_cnt [2], m_acc [2], m_hs [2], d_acc [2], d_hs [2];
  int          n_cmp = 0, n_err = 0;

  bitonic_sort_ctrl #(.DEPTH(8), .WIDTH(32)) u_d8 (
    .clk(clk), .rst(rst), .abort(ab[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .seq_in(s8), .out_valid(ov[0]), .out_ready(ordy[0]), .seq_out(o8), .busy(bz[0]));

  bitonic_sort_ctrl #(.DEPTH(2), .WIDTH(32)) u_d2 (
    .clk(clk), .rst(rst), .abort(ab[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .seq_in(s2), .out_valid(ov[1]), .out_ready(ordy[1]), .seq_out(o2), .busy(bz[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: capture the accepted sequence and sort it with a plain bubble sort.
  task automatic load_sorted(input int k);
    int n;
    logic [31:0] t;
    n = (k == 0) ? 8 : 2;
    if (k == 0) for (int i = 0; i < 8; i++) m_res[k][i] = s8[i];
    else        for (int i = 0; i < 2; i++) m_res[k][i] = s2[i];
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n - 1 - a; b++)
        if (m_res[k][b] > m_res[k][b+1]) begin
          t = m_res[k][b]; m_res[k][b] = m_res[k][b+1]; m_res[k][b+1] = t;
        end
  endtask

  // Model: 0 idle, 1 sorting (countdown of nsub cycles), 2 holding result.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_cnt[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ab[k]) begin
          if (m_st[k] == 2 && ordy[k]) m_hs[k]++;
          m_st[k] = 0;
        end else if (m_st[k] == 0) begin
          if (iv[k]) begin
            load_sorted(k);
            m_cnt[k] = (k == 0) ? nsub(8) : nsub(2);
            m_st[k]  = 1;
            m_acc[k]++;
          end
        end else if (m_st[k] == 1) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_st[k] = 2;
        end else if (ordy[k]) begin
          m_st[k] = 0;
          m_hs[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] a, e;
    int n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 8 : 2;
      chk($sformatf("d%0d.in_ready", n), 64'(ir[k]), 64'((m_st[k] == 0) && !ab[k]));
      chk($sformatf("d%0d.out_valid", n), 64'(ov[k]), 64'(m_st[k] == 2));
      chk($sformatf("d%0d.busy", n), 64'(bz[k]), 64'(m_st[k] != 0));
      for (int i = 0; i < n; i++) begin
        if (k == 0) a = o8[i]; else a = o2[i];
        e = (m_st[k] == 2) ? m_res[k][i] : 32'd0;
        chk($sformatf("d%0d.seq_out[%0d]", n, i), 64'(a), 64'(e));
      end
      if (rst && iv[k] && ir[k]) d_acc[k]++;
      if (rst && ov[k] && ordy[k]) d_hs[k]++;
    end
  end

  task automatic send8(output int lat);
    int w;
    w = 0;
    while (!ir[0] && w < 50) begin tick(); w++; end
    for (int i = 0; i < 8; i++) s8[i] = vin[i];
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 50) begin tick(); lat++; end
  endtask

  task automatic run_vec(input string nm);
    int lat;
    send8(lat);
    chk({nm, "_latency"}, 64'(lat), 64'd6);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_seq_out[%0d]", nm, i), 64'(o8[i]), 64'(vexp[i]));
  endtask

  initial begin
    int b0, b1, c;
    for (int k = 0; k < 2; k++) begin ab[k] = 0; iv[k] = 0; ordy[k] = 0; end
    for (int i = 0; i < 8; i++) s8[i] = '0;
    s2[0] = '0; s2[1] = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_seq_out0", 64'(o8[0]), 64'd0);
    #18 rst = 1'b1;
    tick();

    // descending input, consumer always ready
    ordy[0] = 1'b1;
    vin  = '{7, 6, 5, 4, 3, 2, 1, 0};
    vexp = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_vec("desc");
    tick();
    chk("desc_in_ready_after_hs", 64'(ir[0]), 64'd1);
    chk("desc_out_valid_after_hs", 64'(ov[0]), 64'd0);

    vin  = '{3, 1, 3, 0, 1, 3, 0, 0};
    vexp = '{0, 0, 0, 1, 1, 3, 3, 3};
    run_vec("dups"); tick();
    vin  = '{5, 5, 5, 5, 5, 5, 5, 5};
    vexp = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_vec("equal"); tick();
    vin  = '{32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 32'h7FFF_FFFF, 2, 32'hFFFF_FFFE, 3};
    vexp = '{0, 1, 2, 3, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    run_vec("fullrange"); tick();

    // backpressure in DONE
    ordy[0] = 1'b0;
    vin  = '{10, 3, 7, 3, 0, 255, 1, 2};
    vexp = '{0, 1, 2, 3, 3, 7, 10, 255};
    run_vec("bp");
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1;
      s8[0] = 32'd99;
      tick();
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      chk("bp_in_ready", 64'(ir[0]), 64'd0);
      chk("bp_seq_out0", 64'(o8[0]), 64'd0);
      chk("bp_seq_out7", 64'(o8[7]), 64'd255);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    chk("bp_release_out_valid", 64'(ov[0]), 64'd0);
    chk("bp_release_in_ready", 64'(ir[0]), 64'd1);
    tick();
    chk("bp_no_dup_output", 64'(ov[0]), 64'd0);

    // abort while applying substage 3
    for (int i = 0; i < 8; i++) s8[i] = 32'(8 - i);
    iv[0] = 1'b1; tick(); iv[0] = 1'b0;
    tick(); tick();
    ab[0] = 1'b1;
    tick();
    chk("abort_busy", 64'(bz[0]), 64'd0);
    chk("abort_in_ready_held", 64'(ir[0]), 64'd0);
    ab[0] = 1'b0;
    #1;
    chk("abort_in_ready_free", 64'(ir[0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_output", 64'(ov[0]), 64'd0);
    end
    ab[0] = 1'b1; iv[0] = 1'b1;
    #1;
    chk("abort_idle_in_ready", 64'(ir[0]), 64'd0);
    tick();
    chk("abort_idle_busy", 64'(bz[0]), 64'd0);
    ab[0] = 1'b0; iv[0] = 1'b0;
    tick();
    chk("abort_idle_busy2", 64'(bz[0]), 64'd0);

    // asynchronous reset mid-sort
    for (int i = 0; i < 8; i++) s8[i] = 32'(i * 3);
    iv[0] = 1'b1; tick(); iv[0] = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bz[0]), 64'd0);
    chk("arst_in_ready", 64'(ir[0]), 64'd1);
    chk("arst_out_valid", 64'(ov[0]), 64'd0);
    chk("arst_seq_out3", 64'(o8[3]), 64'd0);
    #3 rst = 1'b1;
    tick();
    vin  = '{2, 0, 1, 3, 7, 5, 6, 4};
    vexp = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_vec("post_rst"); tick();

    // random traffic on both depths
    b0 = d_acc[0]; b1 = d_acc[1];
    c = 0;
    while (c < 20000 && !((d_acc[0] - b0) >= 500 && (d_acc[1] - b1) >= 500)) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 2) != 0);
        ab[k]   = ($urandom_range(0, 99) == 0);
      end
      for (int i = 0; i < 8; i++) s8[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom();
      for (int i = 0; i < 2; i++) s2[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom();
      tick();
      c++;
    end
    chk("rand_d8_enough_sorts", 64'((d_acc[0] - b0) >= 500), 64'd1);
    chk("rand_d2_enough_sorts", 64'((d_acc[1] - b1) >= 500), 64'd1);
    for (int k = 0; k < 2; k++) begin iv[k] = 0; ab[k] = 0; ordy[k] = 1; end
    repeat (12) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("drain_accepts_%0d", k), 64'(d_acc[k]), 64'(m_acc[k]));
      chk($sformatf("drain_outputs_%0d", k), 64'(d_hs[k]), 64'(m_hs[k]));
      chk($sformatf("drain_idle_%0d", k), 64'(bz[k]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
